// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the dot-product MAC sequencer.
// Lane count equals the MAC feedback latency.
package mac_seq_pkg;

    localparam int MAC_LAT   = 3;
    localparam int DEF_DW    = 22;
    localparam int DEF_AW    = 10;
    localparam int DEF_ACC_W = 48;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } mac_seq_state_e;

endpackage

// File: rtl/mac_partial_reduce.sv
// Counts MAC result pulses for one command and folds the final
// lane partials (the last min(len,3) pulses) into one sum.
module mac_partial_reduce
    import mac_seq_pkg::*;
#(
    parameter int AW    = DEF_AW,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             o_valid,
    input  logic [ACC_W-1:0] sum,
    input  logic [AW:0]      len,
    output logic [ACC_W-1:0] acc,
    output logic             reduce_done
);

    localparam logic [AW:0] LANES = (AW + 1)'(MAC_LAT);
    localparam logic [AW:0] ONE   = (AW + 1)'(1);

    logic [AW:0]      idx_q, idx_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             pulse;
    logic             fin;

    assign pulse       = en && o_valid;
    assign fin         = (len < LANES) || (idx_q >= len - LANES);
    assign reduce_done = pulse && (idx_q == len - ONE);
    assign acc         = acc_q;

    // next pulse index and accumulated final partials
    always_comb begin
        idx_d = idx_q;
        acc_d = acc_q;
        if (clr) begin
            idx_d = '0;
            acc_d = '0;
        end else if (pulse) begin
            idx_d = idx_q + ONE;
            if (fin) begin
                acc_d = acc_q + sum;
            end
        end
    end

    // counter and accumulator registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q <= '0;
            acc_q <= '0;
        end else begin
            idx_q <= idx_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: streams operand pairs into a 3-deep MAC,
// interleaving partial sums over 3 lanes, then reduces the lanes.
module mac_dot_seq
    import mac_seq_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int AW    = DEF_AW,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             start_ready,
    input  logic [AW:0]      len,
    input  logic [AW-1:0]    a_base,
    input  logic [AW-1:0]    b_base,
    output logic             mem_rd_en,
    output logic [AW-1:0]    mem_a_addr,
    output logic [AW-1:0]    mem_b_addr,
    input  logic [DW-1:0]    mem_a_rdata,
    input  logic [DW-1:0]    mem_b_rdata,
    output logic             mac_valid,
    output logic [DW-1:0]    mac_a,
    output logic [DW-1:0]    mac_b,
    output logic [ACC_W-1:0] mac_sum_in,
    input  logic             mac_o_valid,
    input  logic [ACC_W-1:0] mac_sum_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic             busy
);

    localparam logic [AW:0] LANES = (AW + 1)'(MAC_LAT);
    localparam logic [AW:0] ONE   = (AW + 1)'(1);

    mac_seq_state_e state_q, state_d;
    logic [AW:0]    cnt_q, cnt_d;
    logic [AW:0]    len_q, len_d;
    logic [AW-1:0]  a_base_q, a_base_d;
    logic [AW-1:0]  b_base_q, b_base_d;
    logic           res_valid_q, res_valid_d;
    logic           mac_valid_q;
    logic [AW:0]    k_q;
    logic           clr;
    logic           red_en;
    logic           reduce_done;

    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign mem_rd_en   = (state_q == ISSUE);
    assign red_en      = (state_q == ISSUE) || (state_q == DRAIN);
    assign res_valid   = res_valid_q;
    assign mac_valid   = mac_valid_q;

    assign mem_a_addr = mem_rd_en ? a_base_q + cnt_q[AW-1:0] : '0;
    assign mem_b_addr = mem_rd_en ? b_base_q + cnt_q[AW-1:0] : '0;

    assign mac_a = mac_valid_q ? mem_a_rdata : '0;
    assign mac_b = mac_valid_q ? mem_b_rdata : '0;
    assign mac_sum_in =
        (mac_valid_q && k_q >= LANES) ? mac_sum_out : '0;

    // command FSM: next state, counters and latched command
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        a_base_d    = a_base_q;
        b_base_d    = b_base_q;
        res_valid_d = res_valid_q;
        clr         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len_d    = len;
                    a_base_d = a_base;
                    b_base_d = b_base;
                    cnt_d    = '0;
                    clr      = 1'b1;
                    state_d  = (len == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + ONE;
                if (cnt_q == len_q - ONE) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (reduce_done) begin
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (!res_valid_q) begin
                    res_valid_d = 1'b1;
                end else if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
        endcase
    end

    // FSM and command registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            a_base_q    <= '0;
            b_base_q    <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            a_base_q    <= a_base_d;
            b_base_q    <= b_base_d;
            res_valid_q <= res_valid_d;
        end
    end

    // read strobe and element index delayed into the issue stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mac_valid_q <= 1'b0;
            k_q         <= '0;
        end else begin
            mac_valid_q <= mem_rd_en;
            k_q         <= mem_rd_en ? cnt_q : '0;
        end
    end

    mac_partial_reduce #(
        .AW   (AW),
        .ACC_W(ACC_W)
    ) u_reduce (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .en         (red_en),
        .o_valid    (mac_o_valid),
        .sum        (mac_sum_out),
        .len        (len_q),
        .acc        (res_data),
        .reduce_done(reduce_done)
    );

endmodule

// File: tb/tb_mac_dot_seq.sv
// Bench for mac_dot_seq with behavioural operand memories and a
// 3-stage MAC; results are checked through a scoreboard queue.
module tb_mac_dot_seq;

    typedef struct {
        logic [47:0] data;
        int          lat;
        int          len;
        int          abase;
        int          bbase;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        start_ready;
    logic [10:0] len = '0;
    logic [9:0]  a_base = '0;
    logic [9:0]  b_base = '0;
    logic        mem_rd_en;
    logic [9:0]  mem_a_addr, mem_b_addr;
    logic [21:0] mem_a_rdata = '0;
    logic [21:0] mem_b_rdata = '0;
    logic        mac_valid;
    logic [21:0] mac_a, mac_b;
    logic [47:0] mac_sum_in;
    logic        mac_o_valid;
    logic [47:0] mac_sum_out;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [47:0] res_data;
    logic        busy;

    int vecs = 0;
    int errs = 0;

    exp_t sbq[$];
    exp_t cur;
    int   cyc = 0;
    int   acc_cyc = 0;
    bit   active = 0;
    bit   rv_prev = 0;
    int   nrd = 0;
    int   nmv = 0;

    logic [21:0] ma [1024];
    logic [21:0] mb [1024];

    always #5 clk = ~clk;

    mac_dot_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_ready(start_ready),
        .len        (len),
        .a_base     (a_base),
        .b_base     (b_base),
        .mem_rd_en  (mem_rd_en),
        .mem_a_addr (mem_a_addr),
        .mem_b_addr (mem_b_addr),
        .mem_a_rdata(mem_a_rdata),
        .mem_b_rdata(mem_b_rdata),
        .mac_valid  (mac_valid),
        .mac_a      (mac_a),
        .mac_b      (mac_b),
        .mac_sum_in (mac_sum_in),
        .mac_o_valid(mac_o_valid),
        .mac_sum_out(mac_sum_out),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .busy       (busy)
    );

    // operand memories, 1-cycle read latency
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_a_rdata <= ma[mem_a_addr];
            mem_b_rdata <= mb[mem_b_addr];
        end
    end

    // 3-stage MAC: sum_out = a*b + sum_in, two edges after sampling
    logic [47:0] ea, eb;
    logic [47:0] p1 = '0, p2 = '0, p3 = '0;
    logic        v1 = 0, v2 = 0, v3 = 0;
    assign ea = {{26{mac_a[21]}}, mac_a};
    assign eb = {{26{mac_b[21]}}, mac_b};
    always @(posedge clk) begin
        v1 <= mac_valid;
        p1 <= ea * eb + mac_sum_in;
        v2 <= v1;
        p2 <= p1;
        v3 <= v2;
        p3 <= p2;
    end
    assign mac_o_valid = v3;
    assign mac_sum_out = p3;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // accept detection and edge counting
    always @(posedge clk) begin
        if (rst && start && start_ready) begin
            acc_cyc = cyc + 1;
            active  = 1;
            nrd     = 0;
            nmv     = 0;
            if (sbq.size() > 0) cur = sbq[0];
        end
        cyc++;
    end

    // monitor: addresses, strobe counts and results
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            active  = 0;
            rv_prev = 0;
        end else begin
            if (active) begin
                if (mem_rd_en) begin
                    chk("addr_a", 64'(mem_a_addr),
                        64'((cur.abase + nrd) % 1024));
                    chk("addr_b", 64'(mem_b_addr),
                        64'((cur.bbase + nrd) % 1024));
                    nrd++;
                end
                if (mac_valid) nmv++;
                if (res_valid && !rv_prev) begin
                    chk("sb_nonempty", 64'(sbq.size() != 0), 1);
                    if (sbq.size() != 0) begin
                        e = sbq.pop_front();
                        chk("res_data", 64'(res_data), 64'(e.data));
                        chk("latency", 64'(cyc - acc_cyc), 64'(e.lat));
                        chk("rd_count", 64'(nrd), 64'(e.len));
                        chk("mv_count", 64'(nmv), 64'(e.len));
                    end
                    active = 0;
                end
            end
            rv_prev = res_valid;
        end
    end

    task automatic ld(int base, int i, int av, int bv);
        ma[(base + i) % 1024] = av[21:0];
        mb[(base + i) % 1024] = bv[21:0];
    endtask

    task automatic issue(int n, int ab, int bb,
                         logic [47:0] d, int lat);
        exp_t e;
        e.data  = d;
        e.lat   = lat;
        e.len   = n;
        e.abase = ab;
        e.bbase = bb;
        sbq.push_back(e);
        @(negedge clk);
        len    = n[10:0];
        a_base = ab[9:0];
        b_base = bb[9:0];
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_done(string nm);
        for (int k = 0; k < 2000; k++) begin
            if (res_valid) break;
            @(negedge clk);
        end
        chk(nm, 64'(res_valid), 1);
    endtask

    task automatic finish_cmd(string nm);
        wait_done(nm);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ma[i] = '0;
            mb[i] = '0;
        end
        repeat (2) @(negedge clk);
        chk("rst_start_ready", 64'(start_ready), 1);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_rd_en", 64'(mem_rd_en), 0);
        chk("rst_mac_valid", 64'(mac_valid), 0);
        chk("rst_res_valid", 64'(res_valid), 0);
        chk("rst_res_data", 64'(res_data), 0);
        chk("rst_addr", 64'(mem_a_addr), 0);
        chk("rst_sum_in", 64'(mac_sum_in), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 64'(start_ready), 1);

        for (int i = 0; i < 4; i++) ld(0, i, i + 1, i + 5);
        issue(4, 0, 0, 48'd70, 8);
        finish_cmd("t_len4");

        ld(10, 0, -3, 7);
        issue(1, 10, 10, -48'sd21, 5);
        finish_cmd("t_len1");

        ld(20, 0, 2, 3);
        ld(20, 1, -2, 5);
        issue(2, 20, 20, -48'sd4, 6);
        finish_cmd("t_len2");

        issue(0, 0, 0, 48'd0, 1);
        finish_cmd("t_len0");

        for (int i = 0; i < 3; i++) ld(30, i, -(1 << 21), -(1 << 21));
        issue(3, 30, 30, 48'd3 << 42, 7);
        finish_cmd("t_big");

        for (int i = 0; i < 7; i++) ld(40, i, i + 1, i + 1);
        issue(7, 40, 40, 48'd140, 11);
        finish_cmd("t_len7");

        ld(1022, 0, 3, 2);
        ld(1022, 1, 1, 7);
        ld(1022, 2, 4, 1);
        ld(1022, 3, 1, 8);
        res_ready = 1'b0;
        issue(4, 1022, 1022, 48'd25, 8);
        wait_done("t_wrap");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_data", 64'(res_data), 25);
            chk("hold_ready", 64'(start_ready), 0);
        end
        len   = 11'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ign_valid", 64'(res_valid), 1);
        chk("ign_busy", 64'(busy), 1);
        res_ready = 1'b1;
        @(negedge clk);
        chk("rel_valid", 64'(res_valid), 0);
        chk("rel_busy", 64'(busy), 0);
        @(negedge clk);
        chk("ign_no_rd", 64'(mem_rd_en), 0);
        chk("ign_idle", 64'(busy), 0);

        for (int i = 0; i < 8; i++) ld(100, i, i + 1, 2);
        issue(8, 100, 100, 48'd0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ab_rd_en", 64'(mem_rd_en), 0);
        chk("ab_mac_valid", 64'(mac_valid), 0);
        chk("ab_busy", 64'(busy), 0);
        chk("ab_res_valid", 64'(res_valid), 0);
        chk("ab_addr", 64'(mem_a_addr), 0);
        chk("ab_ready", 64'(start_ready), 1);
        if (sbq.size() > 0) void'(sbq.pop_back());
        rst = 1'b1;
        repeat (6) @(negedge clk);

        ld(200, 0, 4, 4);
        issue(1, 200, 200, 48'd16, 5);
        finish_cmd("t_after_rst");

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sbq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
